// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative multiply/divide unit that sits in the EX stage next to the ALU.
//   It executes MULTU/MULT/DIVU/DIV into the HI/LO registers and accepts
//   MTHI/MTLO writes. An operation takes a fixed number of cycles. The unit
//   raises busy for the hazard unit while an operation is in flight.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous active-high reset
//   start     in   1      launch op on src_a/src_b (only sampled while idle)
//   op        in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src_a     in   WIDTH  multiplicand / dividend
//   src_b     in   WIDTH  multiplier / divisor
//   hi_we     in   1      MTHI write strobe (only honoured while idle)
//   lo_we     in   1      MTLO write strobe (only honoured while idle)
//   wdata     in   WIDTH  data for MTHI/MTLO
//   busy      out  1      operation in flight
//   done      out  1      one-cycle pulse, HI/LO hold the new result
//   div_zero  out  1      sticky: last divide had a zero divisor
//   hi        out  WIDTH  product high half / remainder
//   lo        out  WIDTH  product low half / quotient

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // MUL: {partial product high, multiplier shifting out}.
  // DIV: low half holds the dividend shifting out / quotient shifting in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               is_div_q, is_div_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed, rem_signed;

  // Operand magnitudes and signs; unsigned ops treat both operands as positive.
  always_comb begin
    sign_a = op[0] & src_a[WIDTH-1];
    sign_b = op[0] & src_b[WIDTH-1];
    a_mag  = sign_a ? -src_a : src_a;
    b_mag  = sign_b ? -src_b : src_b;
  end

  // One iteration of each datapath. The multiply adds with a carry bit so
  // the shifted-in top bit is never lost. The divide keeps a WIDTH+1-bit trial
  // remainder whose top bit is the borrow that decides the quotient bit.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
  end

  // Sign correction applied at FIN. For a zero divisor the remainder path
  // still yields |A|, so restoring the dividend sign gives back the original A.
  always_comb begin
    prod_signed = neg_q ? -acc_q : acc_q;
    quo_signed  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_signed  = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    b_d        = b_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    is_div_d   = is_div_q;
    b_zero_d   = b_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          rem_d     = '0;
          b_d       = b_mag;
          cnt_d     = '0;
          neg_d     = sign_a ^ sign_b;
          rem_neg_d = sign_a;
          is_div_d  = op[1];
          b_zero_d  = (src_b == '0);
          state_d   = op[1] ? DIV : MUL;
          busy_d    = 1'b1;
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = FIN;
      end
      DIV: begin
        rem_d = div_trial[WIDTH] ? div_shift : div_trial;
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = FIN;
      end
      FIN: begin
        if (is_div_q) begin
          lo_d       = b_zero_q ? '1 : quo_signed;
          hi_d       = rem_signed;
          div_zero_d = b_zero_q;
        end else begin
          {hi_d, lo_d} = prod_signed;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      b_q        <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      is_div_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      b_q        <= b_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      is_div_q   <= is_div_d;
      b_zero_q   <= b_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
